// File: rtl/cardinal_pkg.sv
// Shared constants and packet layout for the cardinal NIC / router pair.
package cardinal_pkg;

  localparam int unsigned DATA_W  = 64;
  localparam int unsigned VC_BIT  = 63;
  localparam int unsigned DIR_BIT = 62;
  localparam int unsigned HOP_MSB = 55;
  localparam int unsigned HOP_LSB = 48;
  localparam int unsigned ADDR_W  = 2;
  localparam int unsigned HOP_W   = HOP_MSB - HOP_LSB + 1;
  localparam int unsigned RSVD_W  = DIR_BIT - HOP_MSB - 1;
  localparam int unsigned PLD_W   = HOP_LSB;

  // PE-visible register map
  localparam logic [ADDR_W-1:0] ADDR_IN_BUF   = 2'b00;
  localparam logic [ADDR_W-1:0] ADDR_IN_STAT  = 2'b01;
  localparam logic [ADDR_W-1:0] ADDR_OUT_BUF  = 2'b10;
  localparam logic [ADDR_W-1:0] ADDR_OUT_STAT = 2'b11;

  // Packet layout, MSB first: VC, direction, reserved, hop count, payload
  typedef struct packed {
    logic              vc;
    logic              dir;
    logic [RSVD_W-1:0] rsvd;
    logic [HOP_W-1:0]  hop;
    logic [PLD_W-1:0]  payload;
  } pkt_t;

endpackage

// File: rtl/nic_channel_buf.sv
// One-entry packet register with a full flag, driven by load/unload strobes.
module nic_channel_buf
  import cardinal_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              unload,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q,
  output logic              full
);

  // Load takes priority; callers only load when empty and only unload when full
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q    <= '0;
      full <= 1'b0;
    end else if (load) begin
      q    <= d;
      full <= 1'b1;
    end else if (unload) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/cardinal_nic.sv
// PE-side network interface: one outgoing and one incoming packet slot.
module cardinal_nic
  import cardinal_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] d_out,
  input  logic              nicEn,
  input  logic              nicWrEn,
  output logic              net_so,
  input  logic              net_ro,
  output logic [DATA_W-1:0] net_do,
  input  logic              net_polarity,
  input  logic              net_si,
  output logic              net_ri,
  input  logic [DATA_W-1:0] net_di
);

  pkt_t out_q;
  pkt_t in_q;
  logic out_full;
  logic in_full;
  logic pe_wr;
  logic pe_rd;
  logic out_load;
  logic in_load;
  logic in_unload;

  // PE access decode
  always_comb begin
    pe_wr     = nicEn & nicWrEn;
    pe_rd     = nicEn & ~nicWrEn;
    out_load  = pe_wr & (addr == ADDR_OUT_BUF) & ~out_full;
    in_unload = pe_rd & (addr == ADDR_IN_BUF) & in_full;
  end

  // Router handshakes; a packet leaves only in the phase matching its VC
  always_comb begin
    net_so  = out_full & net_ro & (out_q.vc == net_polarity);
    net_do  = out_q;
    net_ri  = reset & ~in_full;
    in_load = net_si & net_ri;
  end

  nic_channel_buf u_out_buf (
    .clk    (clk),
    .reset  (reset),
    .load   (out_load),
    .unload (net_so),
    .d      (d_in),
    .q      (out_q),
    .full   (out_full)
  );

  nic_channel_buf u_in_buf (
    .clk    (clk),
    .reset  (reset),
    .load   (in_load),
    .unload (in_unload),
    .d      (net_di),
    .q      (in_q),
    .full   (in_full)
  );

  // PE read data register; holds its value when no read is issued
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_out <= '0;
    end else if (pe_rd) begin
      case (addr)
        ADDR_IN_BUF:   d_out <= in_q;
        ADDR_IN_STAT:  d_out <= DATA_W'(in_full);
        ADDR_OUT_BUF:  d_out <= '0;
        ADDR_OUT_STAT: d_out <= DATA_W'(out_full);
        default:       d_out <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_cardinal_nic.sv
// Directed bench for cardinal_nic with hand-computed expected values.
module tb_cardinal_nic;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic [63:0] d_in;
  logic [63:0] d_out;
  logic        nicEn;
  logic        nicWrEn;
  logic        net_so;
  logic        net_ro;
  logic [63:0] net_do;
  logic        net_polarity;
  logic        net_si;
  logic        net_ri;
  logic [63:0] net_di;

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] rd;
  bit ok;

  localparam logic [63:0] PKT_A  = 64'h0007_0001_AAAA_BBCC;
  localparam logic [63:0] PKT_B  = 64'h8003_0002_DDCC_BBAA;
  localparam logic [63:0] PKT_IN = 64'h0000_00BB_8765_4321;
  localparam logic [63:0] PKT_X1 = 64'h00AA_0000_0000_0001;
  localparam logic [63:0] PKT_X2 = 64'h00AA_0000_0000_0002;
  localparam logic [63:0] PKT_C  = 64'h0000_0000_0000_C0C0;
  localparam logic [63:0] PKT_D  = 64'h0011_2233_4455_6677;

  cardinal_nic dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .d_in         (d_in),
    .d_out        (d_out),
    .nicEn        (nicEn),
    .nicWrEn      (nicWrEn),
    .net_so       (net_so),
    .net_ro       (net_ro),
    .net_do       (net_do),
    .net_polarity (net_polarity),
    .net_si       (net_si),
    .net_ri       (net_ri),
    .net_di       (net_di)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running required finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge; router polarity flips each cycle
  task automatic step();
    @(posedge clk);
    #1;
    net_polarity = ~net_polarity;
  endtask

  task automatic pe_write(input logic [1:0] a, input logic [63:0] d);
    nicEn = 1'b1; nicWrEn = 1'b1; addr = a; d_in = d;
    step();
    nicEn = 1'b0; nicWrEn = 1'b0;
  endtask

  task automatic pe_read(input logic [1:0] a, output logic [63:0] data);
    nicEn = 1'b1; nicWrEn = 1'b0; addr = a;
    step();
    nicEn = 1'b0;
    #1;
    data = d_out;
  endtask

  // Wait (bounded) for net_so; it must track the VC-matching phase each cycle.
  // Returns in the send cycle without consuming the transfer edge.
  task automatic wait_send(input string tag, input logic vc, input logic [63:0] exp_do,
                           output bit sent);
    sent = 1'b0;
    for (int i = 0; i < 8 && !sent; i++) begin
      #1;
      check({tag, "_so_phase"}, 64'(net_so), 64'(net_polarity == vc));
      if (net_so) begin
        check({tag, "_do"}, net_do, exp_do);
        sent = 1'b1;
      end else begin
        step();
      end
    end
    if (!sent) check({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  initial begin
    reset = 1'b0; addr = '0; d_in = '0; nicEn = 1'b0; nicWrEn = 1'b0;
    net_ro = 1'b0; net_polarity = 1'b0; net_si = 1'b0; net_di = '0;
    step(); step();
    reset = 1'b1;
    #1;
    check("por_ri", 64'(net_ri), 64'd1);
    check("por_so", 64'(net_so), 64'd0);
    check("por_dout", d_out, 64'd0);

    // 1: fill both slots, then reset asynchronously mid-cycle
    pe_write(2'b10, PKT_C);
    net_si = 1'b1; net_di = PKT_D;
    step();
    net_si = 1'b0;
    pe_read(2'b11, rd); check("t1_out_full", rd, 64'd1);
    pe_read(2'b01, rd); check("t1_in_full", rd, 64'd1);
    #2;
    reset = 1'b0;
    net_ro = 1'b1;
    #1;
    check("t1_rst_ri", 64'(net_ri), 64'd0);
    check("t1_rst_so", 64'(net_so), 64'd0);
    check("t1_rst_do", net_do, 64'd0);
    check("t1_rst_dout", d_out, 64'd0);
    step(); #1; check("t1_rst_so_ph1", 64'(net_so), 64'd0);
    step(); #1; check("t1_rst_so_ph2", 64'(net_so), 64'd0);
    net_ro = 1'b0;
    reset = 1'b1;
    #1;
    check("t1_rel_ri", 64'(net_ri), 64'd1);
    pe_read(2'b11, rd); check("t1_out_stat", rd, 64'd0);
    pe_read(2'b01, rd); check("t1_in_stat", rd, 64'd0);
    pe_read(2'b00, rd); check("t1_in_buf_clr", rd, 64'd0);

    // 2: VC=0 packet leaves only in a pol=0 cycle
    pe_write(2'b10, PKT_A);
    pe_read(2'b11, rd); check("t2_out_full", rd, 64'd1);
    check("t2_do_held", net_do, PKT_A);
    net_ro = 1'b1;
    wait_send("t2", 1'b0, PKT_A, ok);
    step();
    net_ro = 1'b0;
    pe_read(2'b11, rd); check("t2_out_empty", rd, 64'd0);

    // 3: VC=1 packet blocked by net_ro=0, second write dropped
    pe_write(2'b10, PKT_B);
    for (int i = 0; i < 4; i++) begin
      #1; check("t3_blocked_so", 64'(net_so), 64'd0);
      if (i == 1) pe_write(2'b10, 64'h1111_2222_3333_4444);
      else step();
    end
    check("t3_do_kept", net_do, PKT_B);
    net_ro = 1'b1;
    wait_send("t3", 1'b1, PKT_B, ok);
    // write racing the transfer edge sees full and is dropped
    pe_write(2'b10, 64'h0000_0000_0000_2222);
    net_ro = 1'b0;
    pe_read(2'b11, rd); check("t3_race_dropped", rd, 64'd0);

    // 4: router delivery, status, read-out
    #1; check("t4_ri_before", 64'(net_ri), 64'd1);
    net_si = 1'b1; net_di = PKT_IN;
    step();
    net_si = 1'b0; net_di = '0;
    #1; check("t4_ri_full", 64'(net_ri), 64'd0);
    pe_read(2'b01, rd); check("t4_in_stat", rd, 64'd1);
    pe_read(2'b00, rd); check("t4_in_buf", rd, PKT_IN);
    check("t4_ri_after", 64'(net_ri), 64'd1);
    pe_read(2'b01, rd); check("t4_in_stat_clr", rd, 64'd0);

    // 5: back-to-back arrivals, second held off until the read
    net_si = 1'b1; net_di = PKT_X1;
    step();
    net_di = PKT_X2;
    for (int i = 0; i < 3; i++) begin
      #1; check("t5_held_ri", 64'(net_ri), 64'd0);
      step();
    end
    pe_read(2'b00, rd); check("t5_first", rd, PKT_X1);
    check("t5_ri_open", 64'(net_ri), 64'd1);
    step();
    net_si = 1'b0; net_di = '0;
    #1; check("t5_second_taken", 64'(net_ri), 64'd0);
    pe_read(2'b00, rd); check("t5_second", rd, PKT_X2);

    // 6: send and receive on the same edge
    pe_write(2'b10, PKT_C);
    net_ro = 1'b1;
    wait_send("t6", 1'b0, PKT_C, ok);
    net_si = 1'b1; net_di = PKT_D;
    step();
    net_si = 1'b0; net_di = '0; net_ro = 1'b0;
    pe_read(2'b11, rd); check("t6_out_stat", rd, 64'd0);
    pe_read(2'b01, rd); check("t6_in_stat", rd, 64'd1);
    pe_read(2'b00, rd); check("t6_in_buf", rd, PKT_D);
    pe_read(2'b01, rd); check("t6_in_stat_clr", rd, 64'd0);
    pe_read(2'b00, rd); check("t6_stale_read", rd, PKT_D);
    pe_read(2'b01, rd); check("t6_stale_no_flag", rd, 64'd0);
    #1; check("t6_ri", 64'(net_ri), 64'd1);

    // Misc: writes to other addresses are inert, addr 10 reads zero, d_out holds
    pe_write(2'b00, 64'hDEAD_BEEF_0000_0001);
    pe_write(2'b01, 64'hDEAD_BEEF_0000_0002);
    pe_write(2'b11, 64'hDEAD_BEEF_0000_0003);
    pe_read(2'b01, rd); check("m_in_stat", rd, 64'd0);
    pe_read(2'b11, rd); check("m_out_stat", rd, 64'd0);
    pe_read(2'b00, rd); check("m_in_buf", rd, PKT_D);
    step(); step();
    #1; check("m_dout_hold", d_out, PKT_D);
    pe_read(2'b10, rd); check("m_out_buf_rd", rd, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
